// File: rtl/predicate_speculation_tracker_pkg.sv
// Shared types and constants for the predicate speculation tracker slice.
package predicate_speculation_tracker_pkg;

  localparam int TIA_NUM_PREDICATES = 8;
  localparam int TIA_DI_WIDTH       = 6;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int PRED_IW            = $clog2(TIA_NUM_PREDICATES);

  typedef struct packed {
    logic [PRED_IW-1:0] index;
    logic               value;
  } spec_entry_t;

  typedef enum logic {
    TRACK = 1'b0,
    FLUSH = 1'b1
  } tracker_state_t;

endpackage

// File: rtl/predicate_speculation_tracker_if.sv
// Issue/datapath-facing bundle of the speculation tracker; master drives, slave is the tracker.
interface predicate_speculation_tracker_if
  import predicate_speculation_tracker_pkg::*;
#(
  parameter int NUM_PREDICATES = TIA_NUM_PREDICATES,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int DI_WIDTH       = TIA_DI_WIDTH
);
  localparam int IW = $clog2(NUM_PREDICATES);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                      enable;
  logic                      spec_valid;
  logic                      spec_ready;
  logic [IW-1:0]             spec_index;
  logic                      spec_value;
  logic                      resolve_valid;
  logic [DI_WIDTH-1:0]       resolve_di;
  logic                      resolve_value;
  logic                      mispredict;
  logic [IW-1:0]             mispredict_index;
  logic                      corrected_value;
  logic [NUM_PREDICATES-1:0] pending_mask;
  logic [CW-1:0]             outstanding;
  logic                      protocol_error;

  modport master (
    output enable, spec_valid, spec_index, spec_value,
           resolve_valid, resolve_di, resolve_value,
    input  spec_ready, mispredict, mispredict_index, corrected_value,
           pending_mask, outstanding, protocol_error
  );

  modport slave (
    input  enable, spec_valid, spec_index, spec_value,
           resolve_valid, resolve_di, resolve_value,
    output spec_ready, mispredict, mispredict_index, corrected_value,
           pending_mask, outstanding, protocol_error
  );

endinterface

// File: rtl/predicate_speculation_tracker_spec_entry_fifo.sv
// Circular buffer of speculation entries; count alone tells full from empty.
module spec_entry_fifo
  import predicate_speculation_tracker_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  spec_entry_t               push_entry,
  input  logic                      pop,
  input  logic                      clear,
  output spec_entry_t               head_entry,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          live,
  output spec_entry_t               entries [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  spec_entry_t   mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  // Clear wins over push/pop so a squashing resolve drops any same-cycle push.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[tail_q] <= push_entry;
        tail_q      <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    logic [PW-1:0] offset;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset  = PW'(i) - head_q;
      live[i] = (CW'(offset) < count_q);
    end
  end

  assign head_entry = mem[head_q];
  assign count      = count_q;
  assign entries    = mem;

endmodule

// File: rtl/predicate_speculation_tracker.sv
// Checks datapath predicate writes against the predictions issued speculatively; squashes on mispredict.
module predicate_speculation_tracker
  import predicate_speculation_tracker_pkg::*;
#(
  parameter int NUM_PREDICATES = TIA_NUM_PREDICATES,
  parameter int DEPTH          = DEFAULT_DEPTH
) (
  input logic                             clock,
  input logic                             reset,
  predicate_speculation_tracker_if.slave  bus
);

  localparam int IW = $clog2(NUM_PREDICATES);
  localparam int CW = $clog2(DEPTH) + 1;

  tracker_state_t state_q;
  tracker_state_t state_d;

  spec_entry_t   head_entry;
  spec_entry_t   push_entry;
  spec_entry_t   entries [DEPTH];
  logic [CW-1:0] count;
  logic [DEPTH-1:0] live;

  logic resolve_fire;
  logic fifo_empty;
  logic head_match;
  logic resolve_correct;
  logic resolve_wrong_index;
  logic resolve_mispredict;
  logic resolve_empty;
  logic fifo_push;
  logic fifo_pop;
  logic spec_ready;

  logic          mispredict_q;
  logic [IW-1:0] mispredict_index_q;
  logic          corrected_value_q;
  logic          protocol_error_q;
  logic [NUM_PREDICATES-1:0] pending_mask;

  logic unused_di_bits;
  assign unused_di_bits = ^bus.resolve_di[TIA_DI_WIDTH-1:IW];

  assign resolve_fire        = bus.enable && (state_q == TRACK) && bus.resolve_valid;
  assign fifo_empty          = (count == '0);
  assign head_match          = (bus.resolve_di[IW-1:0] == head_entry.index[IW-1:0]);
  assign resolve_empty       = resolve_fire && fifo_empty;
  assign resolve_wrong_index = resolve_fire && !fifo_empty && !head_match;
  assign resolve_correct     = resolve_fire && !fifo_empty && head_match &&
                               (bus.resolve_value == head_entry.value);
  assign resolve_mispredict  = resolve_fire && !fifo_empty && head_match &&
                               (bus.resolve_value != head_entry.value);

  assign fifo_pop   = resolve_correct || resolve_wrong_index;
  assign fifo_push  = bus.spec_valid && spec_ready && !resolve_mispredict;
  assign push_entry = '{index: PRED_IW'(bus.spec_index), value: bus.spec_value};

  spec_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .clear      (resolve_mispredict),
    .head_entry (head_entry),
    .count      (count),
    .live       (live),
    .entries    (entries)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= TRACK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TRACK:   if (resolve_mispredict) state_d = FLUSH;
      FLUSH:   if (bus.enable) state_d = TRACK;
      default: state_d = TRACK;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    spec_ready = 1'b0;
    if (bus.enable && (state_q == TRACK)) begin
      spec_ready = (count < CW'(DEPTH)) || fifo_pop;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mispredict_q       <= 1'b0;
      mispredict_index_q <= '0;
      corrected_value_q  <= 1'b0;
      protocol_error_q   <= 1'b0;
    end else begin
      mispredict_q <= resolve_mispredict;
      if (resolve_mispredict) begin
        mispredict_index_q <= head_entry.index[IW-1:0];
        corrected_value_q  <= bus.resolve_value;
      end
      if (resolve_empty || resolve_wrong_index) begin
        protocol_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pending_mask[entries[i].index[IW-1:0]] = 1'b1;
    end
  end

  assign bus.spec_ready       = spec_ready;
  assign bus.mispredict       = mispredict_q && bus.enable;
  assign bus.mispredict_index = mispredict_index_q;
  assign bus.corrected_value  = corrected_value_q;
  assign bus.pending_mask     = pending_mask;
  assign bus.outstanding      = count;
  assign bus.protocol_error   = protocol_error_q;

endmodule
